// File: rtl/rfsoc_config_pkg.sv
// rtl/rfsoc_config_pkg.sv - shared RFSoC types and widths for the DAC burst reader
package rfsoc_config;

   typedef enum logic [1:0] {
      RD_IDLE,
      RD_ARM,
      RD_STREAM
   } dac_rd_state_t;

   localparam int DAC_WORD_W      = 256;
   localparam int DAC_BURST_LEN_W = 16;

endpackage

// File: rtl/axis_dac_burst_reader.sv
// rtl/axis_dac_burst_reader.sv - drains FIFO words in bursts and registers them toward the DAC
module axis_dac_burst_reader
   import rfsoc_config::*;
#(
   parameter int DATA_W = DAC_WORD_W,
   parameter int LEN_W  = DAC_BURST_LEN_W
) (
   input  logic              axis_clk,
   input  logic              rst,
   input  logic              start,
   input  logic              stop,
   input  logic [LEN_W-1:0]  burst_len,
   input  logic              s_axis_tvalid,
   output logic              s_axis_tready,
   input  logic [DATA_W-1:0] s_axis_tdata,
   output logic [DATA_W-1:0] dac_data,
   output logic              dac_valid,
   output logic              busy,
   output logic              done,
   output logic              underrun,
   output logic [LEN_W-1:0]  words_sent
);

   dac_rd_state_t     state_q, state_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [LEN_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              valid_q, valid_d;
   logic              done_q, done_d;
   logic              underrun_q, underrun_d;
   logic              last_word;

   // The last word is the one that brings the count up to len_q; len_q is never 0 here.
   assign last_word = (cnt_q == (len_q - LEN_W'(1)));

   // Next-state, counter and output-register logic; the DAC word defaults to zero.
   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      cnt_d      = cnt_q;
      data_d     = '0;
      valid_d    = 1'b0;
      done_d     = 1'b0;
      underrun_d = underrun_q;
      case (state_q)
         RD_IDLE: begin
            if (start && !stop) begin
               if (burst_len != '0) begin
                  state_d    = RD_ARM;
                  len_d      = burst_len;
                  cnt_d      = '0;
                  underrun_d = 1'b0;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         RD_ARM: begin
            if (stop) begin
               state_d = RD_IDLE;
            end else if (s_axis_tvalid) begin
               state_d = RD_STREAM;
            end
         end
         RD_STREAM: begin
            if (s_axis_tvalid) begin
               data_d  = s_axis_tdata;
               valid_d = 1'b1;
               cnt_d   = cnt_q + LEN_W'(1);
               if (last_word) begin
                  state_d = RD_IDLE;
                  done_d  = !stop;
               end
            end else begin
               underrun_d = 1'b1;
            end
            // A handshake in the stop cycle is still registered above.
            if (stop) begin
               state_d = RD_IDLE;
            end
         end
         default: state_d = RD_IDLE;
      endcase
   end

   // State and datapath registers with asynchronous active-low reset.
   always_ff @(posedge axis_clk or negedge rst) begin
      if (!rst) begin
         state_q    <= RD_IDLE;
         len_q      <= '0;
         cnt_q      <= '0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         done_q     <= 1'b0;
         underrun_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         cnt_q      <= cnt_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
         done_q     <= done_d;
         underrun_q <= underrun_d;
      end
   end

   // Ready depends only on state so the FIFO never sees a tvalid->tready loop.
   assign s_axis_tready = (state_q == RD_STREAM);
   assign busy          = (state_q != RD_IDLE);
   assign dac_data      = data_q;
   assign dac_valid     = valid_q;
   assign done          = done_q;
   assign underrun      = underrun_q;
   assign words_sent    = cnt_q;

endmodule

// File: tb/tb_axis_dac_burst_reader.sv
// tb/tb_axis_dac_burst_reader.sv - directed self-checking bench for axis_dac_burst_reader
module tb_axis_dac_burst_reader;

   localparam int DATA_W = 256;
   localparam int LEN_W  = 16;

   logic              axis_clk = 1'b0;
   logic              rst = 1'b0;
   logic              start = 1'b0;
   logic              stop = 1'b0;
   logic [LEN_W-1:0]  burst_len = '0;
   logic              s_axis_tvalid = 1'b0;
   logic              s_axis_tready;
   logic [DATA_W-1:0] s_axis_tdata = '0;
   logic [DATA_W-1:0] dac_data;
   logic              dac_valid;
   logic              busy;
   logic              done;
   logic              underrun;
   logic [LEN_W-1:0]  words_sent;

   int n_checks = 0;
   int n_fails  = 0;

   axis_dac_burst_reader #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
      .axis_clk      (axis_clk),
      .rst           (rst),
      .start         (start),
      .stop          (stop),
      .burst_len     (burst_len),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .s_axis_tdata  (s_axis_tdata),
      .dac_data      (dac_data),
      .dac_valid     (dac_valid),
      .busy          (busy),
      .done          (done),
      .underrun      (underrun),
      .words_sent    (words_sent)
   );

   always #5 axis_clk = ~axis_clk;

   task automatic step();
      @(posedge axis_clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Checks the scalar status outputs in one call: tready, busy, valid, done, underrun.
   task automatic check_ctl(input string tag, input logic [4:0] exp);
      check(tag, DATA_W'({s_axis_tready, busy, dac_valid, done, underrun}), DATA_W'(exp));
   endtask

   logic [DATA_W-1:0] w [0:9];

   initial begin
      for (int i = 0; i < 10; i++) begin
         w[i] = {16{16'(16'h1111 * (i + 1) + 16'h0A05)}};
      end

      // Reset state
      step();
      check("reset_data", dac_data, '0);
      check_ctl("reset_ctl", 5'b00000);
      check("reset_words", DATA_W'(words_sent), '0);
      @(negedge axis_clk);
      rst = 1'b1;
      step();

      // burst_len=4, FIFO already holding A..D
      burst_len = 16'd4; start = 1'b1; s_axis_tvalid = 1'b1; s_axis_tdata = w[0];
      step();
      start = 1'b0;
      check_ctl("b4_arm", 5'b01000);
      check("b4_arm_data", dac_data, '0);
      step();
      check_ctl("b4_stream_entry", 5'b11000);
      for (int i = 0; i < 4; i++) begin
         step();
         s_axis_tdata = w[i + 1];
         check($sformatf("b4_word%0d", i), dac_data, w[i]);
         check($sformatf("b4_cnt%0d", i), DATA_W'(words_sent), DATA_W'(i + 1));
         if (i < 3) check_ctl($sformatf("b4_ctl%0d", i), 5'b11100);
      end
      check_ctl("b4_done", 5'b00110);
      s_axis_tvalid = 1'b0;
      step();
      check("b4_idle_data", dac_data, '0);
      check_ctl("b4_idle_ctl", 5'b00000);
      check("b4_words_hold", DATA_W'(words_sent), DATA_W'(4));

      // burst_len=3 with a 2-cycle underrun after the first word
      burst_len = 16'd3; start = 1'b1; s_axis_tvalid = 1'b1; s_axis_tdata = w[5];
      step();
      start = 1'b0;
      check("ur_words_cleared", DATA_W'(words_sent), '0);
      step();
      step();
      check("ur_word0", dac_data, w[5]);
      s_axis_tvalid = 1'b0;
      step();
      check("ur_gap0_data", dac_data, '0);
      check_ctl("ur_gap0_ctl", 5'b11001);
      step();
      check("ur_gap1_data", dac_data, '0);
      check_ctl("ur_gap1_ctl", 5'b11001);
      check("ur_gap_cnt", DATA_W'(words_sent), DATA_W'(1));
      s_axis_tvalid = 1'b1; s_axis_tdata = w[6];
      step();
      check("ur_word1", dac_data, w[6]);
      check_ctl("ur_word1_ctl", 5'b11101);
      s_axis_tdata = w[7];
      step();
      check("ur_word2", dac_data, w[7]);
      check_ctl("ur_done", 5'b00111);
      check("ur_cnt", DATA_W'(words_sent), DATA_W'(3));
      s_axis_tvalid = 1'b0;
      step();
      check_ctl("ur_done_once", 5'b00001);

      // burst_len=8, stop asserted during the 5th handshake
      burst_len = 16'd8; start = 1'b1; s_axis_tvalid = 1'b1; s_axis_tdata = w[0];
      step();
      start = 1'b0;
      check("stop_underrun_cleared", DATA_W'(underrun), '0);
      step();
      for (int i = 0; i < 4; i++) begin
         step();
         s_axis_tdata = w[i + 1];
      end
      stop = 1'b1;
      step();
      stop = 1'b0; s_axis_tvalid = 1'b0;
      check("stop_last_word", dac_data, w[4]);
      check("stop_cnt", DATA_W'(words_sent), DATA_W'(5));
      check_ctl("stop_ctl", 5'b00100);
      step();
      check_ctl("stop_after", 5'b00000);
      check("stop_cnt_hold", DATA_W'(words_sent), DATA_W'(5));

      // start with burst_len=0
      burst_len = 16'd0; start = 1'b1; s_axis_tvalid = 1'b1; s_axis_tdata = w[9];
      step();
      start = 1'b0;
      check_ctl("len0_done", 5'b00010);
      check("len0_data", dac_data, '0);
      step();
      check_ctl("len0_after", 5'b00000);
      check("len0_cnt_kept", DATA_W'(words_sent), DATA_W'(5));

      // start and stop together
      burst_len = 16'd2; start = 1'b1; stop = 1'b1;
      step();
      start = 1'b0; stop = 1'b0;
      check_ctl("startstop", 5'b00000);

      // start during STREAM is ignored; burst still ends after 2 words
      burst_len = 16'd2; start = 1'b1; s_axis_tdata = w[2];
      step();
      start = 1'b0;
      step();
      burst_len = 16'd9; start = 1'b1;
      step();
      start = 1'b0; s_axis_tdata = w[3];
      check("busy_start_w0", dac_data, w[2]);
      step();
      check("busy_start_w1", dac_data, w[3]);
      check_ctl("busy_start_done", 5'b00110);
      check("busy_start_cnt", DATA_W'(words_sent), DATA_W'(2));

      // Reset asserted mid-STREAM
      burst_len = 16'd4; start = 1'b1; s_axis_tdata = w[8];
      step();
      start = 1'b0;
      step();
      step();
      check("rst_pre_word", dac_data, w[8]);
      rst = 1'b0;
      #1;
      check("rst_async_data", dac_data, '0);
      check_ctl("rst_async_ctl", 5'b00000);
      check("rst_async_cnt", DATA_W'(words_sent), '0);
      @(negedge axis_clk);
      rst = 1'b1;
      step();
      check_ctl("rst_release_idle", 5'b00000);
      s_axis_tvalid = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
